rr_pop_arbiter: RTL and testbench

RR_POP_ARBITER -- requirements
Module: rr_pop_arbiter

---
 rtl/rr_pop_arbiter.sv | 119 +++++++++++
 tb/tb_rr_pop_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_pop_arbiter.sv
// ---------------------------------------------------------------------------
// rr_pop_arbiter
//
// Round-robin pop arbiter for NUM_REQS FIFOs. Optional burst hold allows the
// current owner up to BURST consecutive grants before the pointer moves on.
// The grant is combinational, so it reaches the FIFO pops in the same cycle
// as the request.
//
// Configuration macro:
//   ARB_BURST_EN  defined   -> burst hold of up to BURST grants per owner
//                 undefined -> pure round-robin, rotating after every grant
//
// Ports:
//   clk      in   clock; all state updates on the rising edge
//   rst      in   asynchronous, active-low reset
//   reqs     in   [NUM_REQS]  per-requester pop requests
//   empty    in   [NUM_REQS]  per-FIFO empty flags
//   stall    in   downstream backpressure
//   gnt      out  [NUM_REQS]  one-hot or zero grant (drives the FIFO pops)
//   gnt_vld  out  OR of all gnt bits
//   gnt_idx  out  [TAGWIDTH]  binary index of the grant, 0 when gnt_vld=0
//
// Handshake: a requester is eligible when reqs=1 and empty=0. While stall=0,
// an eligible requester that sees its gnt bit pops exactly one entry on that
// clock edge. stall=1 suppresses every grant and freezes all arbiter state,
// so an interrupted burst resumes where it stopped.
// ---------------------------------------------------------------------------
module rr_pop_arbiter #(
    parameter int NUM_REQS = 4,
    parameter int BURST    = 4,
    parameter int TAGWIDTH = $clog2(NUM_REQS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REQS-1:0] reqs,
    input  logic [NUM_REQS-1:0] empty,
    input  logic                stall,
    output logic [NUM_REQS-1:0] gnt,
    output logic                gnt_vld,
    output logic [TAGWIDTH-1:0] gnt_idx
);

    logic [NUM_REQS-1:0] guarded;
    logic [TAGWIDTH-1:0] ptr;        // last granted index
    logic                owner_vld;  // ptr refers to a live owner
    logic                hold;       // owner keeps the grant this cycle
    logic                found;      // some eligible requester exists
    logic [TAGWIDTH-1:0] sel;        // chosen index
    logic [TAGWIDTH-1:0] cand;       // search candidate

`ifdef ARB_BURST_EN
    localparam int CNTW = $clog2(BURST + 1);
    logic [CNTW-1:0] burst_cnt;      // grants given to the current owner
`endif

    assign guarded = reqs & ~empty;

    always_comb begin
        hold    = 1'b0;
        found   = 1'b0;
        sel     = '0;
        cand    = '0;
        gnt     = '0;
        gnt_idx = '0;

`ifdef ARB_BURST_EN
        hold = owner_vld && guarded[ptr] && (burst_cnt < CNTW'(BURST));
`endif

        if (hold) begin
            found = 1'b1;
            sel   = ptr;
        end else begin
            // Search ptr+1, ptr+2, ... wrapping, with ptr itself last. This
            // also re-grants an exhausted owner when nobody else is eligible.
            for (int k = 1; k <= NUM_REQS; k++) begin
                cand = TAGWIDTH'((int'(ptr) + k) % NUM_REQS);
                if (!found && guarded[cand]) begin
                    found = 1'b1;
                    sel   = cand;
                end
            end
        end

        // Reset is folded in combinationally so the pops are silent the
        // moment rst falls, not just after the next edge.
        if (rst && !stall && found) begin
            gnt[sel] = 1'b1;
            gnt_idx  = sel;
        end
    end

    assign gnt_vld = |gnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr       <= TAGWIDTH'(NUM_REQS - 1);  // index 0 wins first
            owner_vld <= 1'b0;
`ifdef ARB_BURST_EN
            burst_cnt <= '0;
`endif
        end else if (!stall) begin
            if (gnt_vld) begin
                ptr       <= gnt_idx;
                owner_vld <= 1'b1;
`ifdef ARB_BURST_EN
                // hold is only true below BURST, so this never overflows.
                burst_cnt <= hold ? burst_cnt + CNTW'(1) : CNTW'(1);
`endif
            end else begin
                owner_vld <= 1'b0;
`ifdef ARB_BURST_EN
                burst_cnt <= '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_rr_pop_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_pop_arbiter
//
// Directed scenarios (full contention, single requester, empty masking,
// stall mid-burst, owner drop, async reset mid-burst) followed by random
// traffic, all compared against a behavioural model of the arbitration rules.
// Works with and without ARB_BURST_EN.
// ---------------------------------------------------------------------------
module tb_rr_pop_arbiter;

  localparam int N = 4;
  localparam int B = 2;
`ifdef ARB_BURST_EN
  localparam int BEFF = B;
`else
  localparam int BEFF = 1;
`endif

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] reqs = '0;
  logic [N-1:0] empty = '0;
  logic         stall = 1'b0;
  logic [N-1:0] gnt;
  logic         gnt_vld;
  logic [1:0]   gnt_idx;

  always #5 clk = ~clk;

  rr_pop_arbiter #(.NUM_REQS(N), .BURST(B), .TAGWIDTH(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .reqs    (reqs),
    .empty   (empty),
    .stall   (stall),
    .gnt     (gnt),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_last: index that most recently received a grant (N-1 after reset).
  // m_run : how many grants in a row m_last has had (0 = no live owner).
  int m_last = N - 1;
  int m_run  = 0;
  bit m_hold;

  function automatic int model_pick(input logic [N-1:0] g, input logic st);
    m_hold = 1'b0;
    if (st || g == '0) return -1;
    if (m_run > 0 && g[m_last] && m_run < BEFF) begin
      m_hold = 1'b1;
      return m_last;
    end
    for (int k = 1; k <= N; k++)
      if (g[(m_last + k) % N]) return (m_last + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_last = N - 1;
    m_run  = 0;
  endtask

  // exp_q holds the expected grant for each directed cycle that is also
  // cross-checked against a literal sequence.
  logic [N-1:0] exp_q[$];
  logic [N-1:0] last_obs;

  // ---------------- driver ----------------
  // Called at posedge+1. Drives inputs, checks at the falling edge, then
  // advances the model across the rising edge.
  task automatic drive_cycle(input logic [N-1:0] r, input logic [N-1:0] e,
                             input logic s, input string tag);
    int           ei;
    logic [N-1:0] eg;
    reqs  = r;
    empty = e;
    stall = s;
    #4;
    ei = model_pick(r & ~e, s);
    eg = (ei < 0) ? '0 : N'(1) << ei;
    last_obs = gnt;
    check_eq({tag, "_gnt"}, 32'(gnt), 32'(eg));
    check_eq({tag, "_vld"}, 32'(gnt_vld), 32'(ei >= 0));
    check_eq({tag, "_idx"}, 32'(gnt_idx), (ei < 0) ? 32'd0 : 32'(ei));
    @(posedge clk);
    if (!s) begin
      if (ei < 0) m_run = 0;
      else begin
        m_run  = m_hold ? m_run + 1 : 1;
        m_last = ei;
      end
    end
    #1;
  endtask

  // Reset asserted between edges; outputs must go quiet immediately.
  task automatic pulse_reset(input string tag);
    rst = 1'b0;
    #1;
    check_eq({tag, "_rst_gnt"}, 32'(gnt), 32'd0);
    check_eq({tag, "_rst_vld"}, 32'(gnt_vld), 32'd0);
    check_eq({tag, "_rst_idx"}, 32'(gnt_idx), 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic drain_seq(input string tag);
    while (exp_q.size() > 0) begin
      drive_cycle(4'b1111, 4'b0000, 1'b0, tag);
      check_eq({tag, "_seq"}, 32'(last_obs), 32'(exp_q.pop_front()));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reqs = 4'b1111;
    @(posedge clk);
    #1;
    // Reset state with everyone requesting.
    check_eq("reset_gnt", 32'(gnt), 32'd0);
    check_eq("reset_vld", 32'(gnt_vld), 32'd0);
    check_eq("reset_idx", 32'(gnt_idx), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Full contention.
`ifdef ARB_BURST_EN
    exp_q = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100,
              4'b1000, 4'b1000, 4'b0001};
`else
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    drain_seq("full");

    // Single requester: owner 2 held every cycle (burst counter wraps).
    pulse_reset("single");
    for (int i = 0; i < 4; i++) begin
      drive_cycle(4'b0100, 4'b0000, 1'b0, "single");
      check_eq("single_lit", 32'(last_obs), 32'(4'b0100));
    end

    // Empty masking.
    pulse_reset("mask");
    for (int i = 0; i < 12; i++) begin
      drive_cycle(4'b1111, 4'b0101, 1'($urandom_range(0, 3) == 0), "mask");
      check_eq("mask_never", 32'(last_obs & 4'b0101), 32'd0);
    end

    // Stall mid-burst.
    pulse_reset("stall");
    drive_cycle(4'b1111, 4'b0000, 1'b0, "stall");
    check_eq("stall_first", 32'(last_obs), 32'(4'b0001));
    for (int i = 0; i < 3; i++) begin
      drive_cycle(4'b1111, 4'b0000, 1'b1, "stall");
      check_eq("stall_quiet", 32'(last_obs), 32'd0);
    end
`ifdef ARB_BURST_EN
    exp_q = '{4'b0001, 4'b0010};
`else
    exp_q = '{4'b0010, 4'b0100};
`endif
    drain_seq("stall_resume");

    // Owner drop mid-burst: new owner 1 starts a fresh burst.
    pulse_reset("drop");
    drive_cycle(4'b1111, 4'b0000, 1'b0, "drop");
    drive_cycle(4'b1110, 4'b0000, 1'b0, "drop");
    check_eq("drop_rotate", 32'(last_obs), 32'(4'b0010));
    drive_cycle(4'b1110, 4'b0000, 1'b0, "drop");
    check_eq("drop_next", 32'(last_obs), (BEFF == 2) ? 32'(4'b0010) : 32'(4'b0100));

    // Async reset mid-burst; burst must not resume afterwards.
    drive_cycle(4'b1111, 4'b0000, 1'b0, "areset");
    pulse_reset("areset");
    drive_cycle(4'b1111, 4'b0000, 1'b0, "areset");
    check_eq("areset_first", 32'(last_obs), 32'(4'b0001));

    // Random traffic with occasional stalls and resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) pulse_reset("rand");
      drive_cycle(4'($urandom_range(0, 15)),
                  ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 5) == 0), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected end of stimulus");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
